fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Decoupling queue on the consumer side of the fetch stage. It accepts {pc, tag, instruction} beats from fetch and the instruction memory, holds them in a small FIFO, and presents them to decode through a valid/ready handshake. Entries whose tag no longer matches the architectural tag are silently dropped. A front-end redirect (jump, exception, mret, interrupt) empties the queue in one cycle.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- flush_i  in  1  drop every entry, including any write in the same cycle.
- expected_tag_i  in  3  tag currently accepted by decode/execute.
- valid_i  in  1  beat from fetch is present.
- ready_o  out  1  buffer can accept a beat; equals count_o != DEPTH.
- pc_i  in  32  instruction PC.
- tag_i  in  3  fetch tag.
- instruction_i  in  32  instruction word from memory.
- valid_o  out  1  head beat is valid and its tag matches.
- ready_i  in  1  decode consumes the head this cycle.
- pc_o  out  32  head PC.
- tag_o  out  3  head tag.
- instruction_o  out  32  head instruction.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage: circular array of DEPTH entries with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. The count is a separate register.
- Write: when valid_i & ready_o & ~flush_i, store the entry at wr_ptr and increment wr_ptr.
- Head match: head_ok = (count != 0) & (head.tag == expected_tag_i).
- valid_o = head_ok.
- Pop conditions (at most one per cycle):
  - consume: valid_o & ready_i;
  - discard: count != 0 & head.tag != expected_tag_i, regardless of ready_i.
- Count update: +1 on write only, −1 on pop only, unchanged on write and pop together.
- Flush: rd_ptr, wr_ptr and count go to 0 next cycle. A flush has priority over a simultaneous write and pop. Storage contents are left untouched.
- Full: ready_o = 0 when count == DEPTH. A simultaneous pop does not raise ready_o in the same cycle (no pass-through when full).
- Empty: valid_o = 0. pc_o, tag_o and instruction_o show the stale entry at rd_ptr.
- Data outputs are valid only while valid_o = 1; the bench checks them only then.

## Timing
- Reset values:
  - count_o = 0, rd_ptr = wr_ptr = 0;
  - all storage cleared, so pc_o = 0, tag_o = 0, instruction_o = 0;
  - valid_o = 0;
  - ready_o = 0 while reset is asserted, 1 from the first cycle after.
- Latency without bypass: a beat written at edge N drives valid_o in cycle N+1 if its tag matches.
- ready_o is a function of registered count only; it has no combinational path from ready_i or valid_i.
- valid_o depends combinationally on expected_tag_i.
- Discard rate is one mismatching entry per cycle. After a tag change, DEPTH stale entries drain in at most DEPTH cycles. Decode normally flushes instead.
- Reset mid-operation: all entries are lost and the next cycle behaves as after power-up.

## Configuration
- FETCH_BUFFER_BYPASS_EN defined:
  - condition: count == 0 & valid_i & tag_i == expected_tag_i & ~flush_i;
  - the input beat drives pc_o, tag_o, instruction_o and valid_o combinationally;
  - if ready_i is also high, the beat is consumed and not written, so latency is 0;
  - otherwise it is written normally.
- FETCH_BUFFER_BYPASS_EN undefined: no combinational input→output path; minimum latency is 1 cycle.

## Structure
- Shared package fetch_pkg:
  - TAG_WIDTH = 3;
  - typedef struct packed {logic [31:0] pc; logic [TAG_WIDTH-1:0] tag; logic [31:0] instruction;} fetch_entry_t.
- No sub-module. Storage is a fetch_entry_t array inside fetch_buffer, with pointer and count logic inline.

## Test plan
- Fill/drain, DEPTH = 4, expected_tag_i = 0:
  - stimulus: write pc 0x100, 0x104, 0x108, 0x10C with ready_i = 0;
  - check: count_o = 4, ready_o = 0;
  - then raise ready_i: check 4 pops in order, valid_o falls after the fourth, ready_o returns to 1.
- Simultaneous read/write: count = 2, valid_i = 1 and ready_i = 1 each cycle for 8 cycles → count stays 2 and PCs come out in order across pointer wrap.
- Tag discard:
  - stimulus: queue tags 0, 0, 1, 1 and set expected_tag_i = 1 with ready_i = 0;
  - check: the two tag-0 entries vanish in 2 cycles, valid_o = 0 during them, then the head is the first tag-1 entry.
- Flush priority: count = 3 with flush_i, valid_i and ready_i all high → count_o = 0 next cycle, valid_o = 0, and the input beat is not stored.
- Full with pop: count = 4, ready_i = 1, valid_i = 1 → ready_o stays 0 that cycle, count becomes 3, and the input is not taken.
- Bypass, with FETCH_BUFFER_BYPASS_EN defined:
  - stimulus: empty buffer, valid_i with pc 0x200 and matching tag, ready_i = 1;
  - check: valid_o = 1 and pc_o = 0x200 in the same cycle, count_o stays 0;
  - without the macro: valid_o rises one cycle later.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the fetch-side decoupling queue: tag width and the
// {pc, tag, instruction} beat layout carried from fetch into decode.
package fetch_pkg;

   localparam int TAG_WIDTH = 3;

   typedef struct packed {
      logic [31:0]          pc;
      logic [TAG_WIDTH-1:0] tag;
      logic [31:0]          instruction;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Fetch-to-decode decoupling FIFO that silently drops stale-tag beats and empties on flush.
// Define FETCH_BUFFER_BYPASS_EN for a zero-latency empty-queue path from input to head.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush_i,
   input  logic [TAG_WIDTH-1:0]       expected_tag_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [31:0]                pc_i,
   input  logic [TAG_WIDTH-1:0]       tag_i,
   input  logic [31:0]                instruction_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [31:0]                pc_o,
   output logic [TAG_WIDTH-1:0]       tag_o,
   output logic [31:0]                instruction_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   fetch_entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0]       r_rdPtr;
   logic [PTR_W-1:0]       r_wrPtr;
   logic [CNT_W-1:0]       r_count;

   fetch_entry_t           w_head;
   fetch_entry_t           w_inBeat;
   logic                   w_notEmpty;
   logic                   w_headMatch;
   logic                   w_headOk;
   logic                   w_pop;
   logic                   w_write;
   logic                   w_bypass;
   logic                   w_bypassTaken;

   assign w_head      = r_mem[r_rdPtr];
   assign w_inBeat    = '{pc: pc_i, tag: tag_i, instruction: instruction_i};
   assign w_notEmpty  = (r_count != '0);
   assign w_headMatch = (w_head.tag == expected_tag_i);
   assign w_headOk    = w_notEmpty & w_headMatch;

   // A mismatching head is discarded regardless of ready_i, one per cycle.
   assign w_pop       = (w_headOk & ready_i) | (w_notEmpty & ~w_headMatch);

   // Full blocks input even if the head pops this cycle; no pass-through.
   assign ready_o     = ~reset & (r_count != FULL_COUNT);

`ifdef FETCH_BUFFER_BYPASS_EN
   assign w_bypass      = ~w_notEmpty & valid_i & (tag_i == expected_tag_i) & ~flush_i;
   assign w_bypassTaken = w_bypass & ready_i;
`else
   assign w_bypass      = 1'b0;
   assign w_bypassTaken = 1'b0;
`endif

   assign w_write = valid_i & ready_o & ~flush_i & ~w_bypassTaken;

   assign valid_o       = w_bypass | w_headOk;
   assign pc_o          = w_bypass ? w_inBeat.pc          : w_head.pc;
   assign tag_o         = w_bypass ? w_inBeat.tag         : w_head.tag;
   assign instruction_o = w_bypass ? w_inBeat.instruction : w_head.instruction;
   assign count_o       = r_count;

   // Flush resets pointers and count but leaves storage alone; reset also clears storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush_i) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_write) begin
            r_mem[r_wrPtr] <= w_inBeat;
            r_wrPtr        <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         if (w_write && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_write && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_fetch_buffer;
   import fetch_pkg::*;

   localparam int DEPTH = 4;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 flush_i = 1'b0;
   logic [TAG_WIDTH-1:0] expected_tag_i = '0;
   logic                 valid_i = 1'b0;
   logic                 ready_o;
   logic [31:0]          pc_i = '0;
   logic [TAG_WIDTH-1:0] tag_i = '0;
   logic [31:0]          instruction_i = '0;
   logic                 valid_o;
   logic                 ready_i = 1'b0;
   logic [31:0]          pc_o;
   logic [TAG_WIDTH-1:0] tag_o;
   logic [31:0]          instruction_o;
   logic [$clog2(DEPTH):0] count_o;

   int checks = 0;
   int failures = 0;
   fetch_entry_t modelQ[$];

   fetch_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .flush_i(flush_i),
      .expected_tag_i(expected_tag_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .pc_i(pc_i),
      .tag_i(tag_i),
      .instruction_i(instruction_i),
      .valid_o(valid_o),
      .ready_i(ready_i),
      .pc_o(pc_o),
      .tag_o(tag_o),
      .instruction_o(instruction_o),
      .count_o(count_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", name, observed, expected, $time);
      end
   endtask

   function automatic bit modelBypass();
      bit byp;
      byp = 1'b0;
`ifdef FETCH_BUFFER_BYPASS_EN
      byp = (modelQ.size() == 0) && valid_i && (tag_i == expected_tag_i) && !flush_i;
`endif
      return byp;
   endfunction

   // Compare the combinational view of the DUT against the model before the edge.
   task automatic checkModel();
      bit           byp;
      bit           expValid;
      fetch_entry_t expHead;
      byp      = modelBypass();
      expValid = byp || (modelQ.size() != 0 && modelQ[0].tag == expected_tag_i);
      if (byp)
         expHead = '{pc: pc_i, tag: tag_i, instruction: instruction_i};
      else if (modelQ.size() != 0)
         expHead = modelQ[0];
      else
         expHead = '0;
      checkOutput("count", 32'(count_o), 32'(modelQ.size()));
      checkOutput("ready", 32'(ready_o), 32'(modelQ.size() != DEPTH));
      checkOutput("valid", 32'(valid_o), 32'(expValid));
      if (expValid) begin
         checkOutput("pc", pc_o, expHead.pc);
         checkOutput("tag", 32'(tag_o), 32'(expHead.tag));
         checkOutput("instr", instruction_o, expHead.instruction);
      end
   endtask

   // Advance the model by one clock edge using the inputs still being driven.
   task automatic updateModel();
      bit byp;
      bit pop;
      bit wr;
      if (flush_i) begin
         modelQ.delete();
         return;
      end
      byp = modelBypass();
      pop = (modelQ.size() != 0) && ((modelQ[0].tag != expected_tag_i) || ready_i);
      wr  = valid_i && (modelQ.size() != DEPTH) && !(byp && ready_i);
      if (pop) void'(modelQ.pop_front());
      if (wr) modelQ.push_back('{pc: pc_i, tag: tag_i, instruction: instruction_i});
   endtask

   task automatic applyStimulus(input logic fl, input logic vi, input logic [31:0] pc,
                                input logic [TAG_WIDTH-1:0] tg, input logic [31:0] ins,
                                input logic ri, input logic [TAG_WIDTH-1:0] et);
      @(negedge clk);
      flush_i        = fl;
      valid_i        = vi;
      pc_i           = pc;
      tag_i          = tg;
      instruction_i  = ins;
      ready_i        = ri;
      expected_tag_i = et;
      #1;
      checkModel();
      @(posedge clk);
      updateModel();
   endtask

   task automatic applyReset();
      @(negedge clk);
      reset   = 1'b1;
      flush_i = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b0;
      #1;
      checkOutput("readyInReset", 32'(ready_o), 32'd0);
      repeat (2) @(posedge clk);
      modelQ.delete();
      @(negedge clk);
      #1;
      checkOutput("resetCount", 32'(count_o), 32'd0);
      checkOutput("resetValid", 32'(valid_o), 32'd0);
      checkOutput("resetPc", pc_o, 32'd0);
      checkOutput("resetTag", 32'(tag_o), 32'd0);
      checkOutput("resetInstr", instruction_o, 32'd0);
      checkOutput("resetReadyHeld", 32'(ready_o), 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("readyAfterReset", 32'(ready_o), 32'd1);
   endtask

   initial begin
      logic [TAG_WIDTH-1:0] et;
      logic [TAG_WIDTH-1:0] tg;
      applyReset();

      // Fill four beats with decode stalled, then drain in order.
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 1, 32'h100 + 32'(4 * i), 3'd0, $urandom, 0, 3'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 3'd0);
      checkOutput("fillCount", 32'(count_o), 32'd4);
      checkOutput("fillReady", 32'(ready_o), 32'd0);
      for (int i = 0; i < 5; i++)
         applyStimulus(0, 0, 0, 0, 0, 1, 3'd0);

      // Steady state at count 2 with simultaneous push and pop across pointer wrap.
      applyStimulus(0, 1, 32'h300, 3'd0, $urandom, 0, 3'd0);
      applyStimulus(0, 1, 32'h304, 3'd0, $urandom, 0, 3'd0);
      for (int i = 0; i < 8; i++)
         applyStimulus(0, 1, 32'h308 + 32'(4 * i), 3'd0, $urandom, 1, 3'd0);
      checkOutput("steadyCount", 32'(count_o), 32'd2);
      applyStimulus(1, 0, 0, 0, 0, 0, 3'd0);

      // Tag change: two stale entries drain while the new-tag entries survive.
      applyStimulus(0, 1, 32'h400, 3'd0, $urandom, 0, 3'd0);
      applyStimulus(0, 1, 32'h404, 3'd0, $urandom, 0, 3'd0);
      applyStimulus(0, 1, 32'h408, 3'd1, $urandom, 0, 3'd0);
      applyStimulus(0, 1, 32'h40C, 3'd1, $urandom, 0, 3'd0);
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 0, 0, 0, 0, 0, 3'd1);
      checkOutput("discardHeadPc", pc_o, 32'h408);
      applyStimulus(1, 0, 0, 0, 0, 0, 3'd1);

      // Flush wins over a simultaneous write and pop.
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 1, 32'h500 + 32'(4 * i), 3'd1, $urandom, 0, 3'd1);
      applyStimulus(1, 1, 32'h5F0, 3'd1, $urandom, 1, 3'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 3'd1);
      checkOutput("flushCount", 32'(count_o), 32'd0);

      // Full with pop: input refused, count drops to three.
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 1, 32'h600 + 32'(4 * i), 3'd2, $urandom, 0, 3'd2);
      applyStimulus(0, 1, 32'h6F0, 3'd2, $urandom, 1, 3'd2);
      applyStimulus(0, 0, 0, 0, 0, 0, 3'd2);
      checkOutput("fullPopCount", 32'(count_o), 32'd3);
      checkOutput("fullPopHead", pc_o, 32'h604);
      applyStimulus(1, 0, 0, 0, 0, 0, 3'd2);

      // Empty-queue beat with decode ready: same-cycle with bypass, next cycle without.
      applyStimulus(0, 1, 32'h200, 3'd2, 32'hCAFE_0001, 1, 3'd2);
      applyStimulus(0, 0, 0, 0, 0, 1, 3'd2);
      applyStimulus(0, 0, 0, 0, 0, 1, 3'd2);

      // Random traffic with occasional tag changes, flushes and one mid-run reset.
      et = 3'd0;
      for (int c = 0; c < 1500; c++) begin
         if (c == 700) applyReset();
         if ($urandom_range(99) < 3) et = 3'($urandom);
         tg = ($urandom_range(99) < 80) ? et : 3'($urandom);
         applyStimulus($urandom_range(99) < 4, $urandom_range(99) < 70, $urandom,
                       tg, $urandom, $urandom_range(99) < 60, et);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
